// File: rtl/rob_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rob_commit_ctrl
//
// In-order reorder-buffer sequencer. It drives both ports of the rename/regfile
// block: the rename port on the decode side and the commit port on the retire
// side. CDB results are captured into allocated entries. A mispredicted branch
// that reaches the head retires normally and also raises a one-cycle br_flush.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   alloc_valid/rd    decode offer and its destination register
//   alloc_ready       ROB can take the offer this cycle
//   alloc_rob_entry   tag the offered instruction would receive (tail)
//   rob_we            rename write strobe (allocation fires)
//   rob_rd_addr       rename destination (= alloc_rd)
//   decode_rob_entry  rename tag (= tail)
//   cdb_*             result broadcast: tag, data, mispredict flag, target PC
//   regf_we           commit write strobe
//   rd_addr/rd_data   head destination and result
//   commit_rob_entry  head tag
//   br_flush/flush_pc redirect pulse and the correct PC
// ---------------------------------------------------------------------------
module rob_commit_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_LENGTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ROB_WIDTH  = $clog2(ROB_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  // decode / rename side
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_rd,
  output logic                  alloc_ready,
  output logic [ROB_WIDTH-1:0]  alloc_rob_entry,
  output logic                  rob_we,
  output logic [ADDR_WIDTH-1:0] rob_rd_addr,
  output logic [ROB_WIDTH-1:0]  decode_rob_entry,
  // writeback side
  input  logic                  cdb_valid,
  input  logic [ROB_WIDTH-1:0]  cdb_rob,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  cdb_mispredict,
  input  logic [31:0]           cdb_target,
  // commit side
  output logic                  regf_we,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ROB_WIDTH-1:0]  commit_rob_entry,
  output logic                  br_flush,
  output logic [31:0]           flush_pc
);

  localparam logic [ROB_WIDTH-1:0] TAG_ONE   = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH-1:0] TAG_ZERO  = {ROB_WIDTH{1'b0}};
  localparam logic [ROB_WIDTH:0]   CNT_ONE   = {{ROB_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH:0]   CNT_ZERO  = {(ROB_WIDTH+1){1'b0}};
  localparam logic [ROB_WIDTH:0]   CNT_FULL  = (ROB_WIDTH+1)'(ROB_LENGTH);

  // Pointer and occupancy state
  logic [ROB_WIDTH-1:0]  head_r;
  logic [ROB_WIDTH-1:0]  tail_r;
  logic [ROB_WIDTH:0]    count_r;

  // Per-entry state
  logic [ROB_LENGTH-1:0] valid_r;
  logic [ROB_LENGTH-1:0] ready_r;
  logic [ROB_LENGTH-1:0] mis_r;
  logic [ADDR_WIDTH-1:0] rd_r   [ROB_LENGTH];
  logic [DATA_WIDTH-1:0] data_r [ROB_LENGTH];
  logic [31:0]           tgt_r  [ROB_LENGTH];

  // Control decisions for the current cycle
  logic commit_s;
  logic flush_s;
  logic alloc_fire_s;
  logic cdb_hit_s;

  // Derive commit, flush, allocation and CDB-capture decisions from current state.
  // Everything is gated with rst so a reset cycle neither commits nor allocates.
  always_comb begin
    commit_s     = 1'b0;
    flush_s      = 1'b0;
    alloc_fire_s = 1'b0;
    cdb_hit_s    = 1'b0;
    alloc_ready  = 1'b0;
    if (rst) begin
      commit_s     = 1'b0;
      flush_s      = 1'b0;
      alloc_ready  = 1'b0;
      alloc_fire_s = 1'b0;
      cdb_hit_s    = 1'b0;
    end else begin
      commit_s     = valid_r[head_r] && ready_r[head_r];
      flush_s      = commit_s && mis_r[head_r];
      // A full ROB stays closed even if the head retires this cycle.
      alloc_ready  = (count_r != CNT_FULL) && !flush_s;
      alloc_fire_s = alloc_valid && alloc_ready;
      // Results for entries that are not allocated are dropped.
      cdb_hit_s    = cdb_valid && valid_r[cdb_rob] && !flush_s;
    end
  end

  // Drive rename and commit ports; all forced to zero while rst is high.
  always_comb begin
    rob_we           = 1'b0;
    rob_rd_addr      = {ADDR_WIDTH{1'b0}};
    decode_rob_entry = TAG_ZERO;
    alloc_rob_entry  = TAG_ZERO;
    regf_we          = 1'b0;
    rd_addr          = {ADDR_WIDTH{1'b0}};
    rd_data          = {DATA_WIDTH{1'b0}};
    commit_rob_entry = TAG_ZERO;
    br_flush         = 1'b0;
    flush_pc         = 32'h0000_0000;
    if (rst) begin
      rob_we  = 1'b0;
      regf_we = 1'b0;
    end else begin
      alloc_rob_entry = tail_r;
      rob_we          = alloc_fire_s;
      if (alloc_fire_s) begin
        rob_rd_addr      = alloc_rd;
        decode_rob_entry = tail_r;
      end else begin
        rob_rd_addr      = {ADDR_WIDTH{1'b0}};
        decode_rob_entry = TAG_ZERO;
      end
      regf_we = commit_s;
      if (commit_s) begin
        rd_addr          = rd_r[head_r];
        rd_data          = data_r[head_r];
        commit_rob_entry = head_r;
      end else begin
        rd_addr          = {ADDR_WIDTH{1'b0}};
        rd_data          = {DATA_WIDTH{1'b0}};
        commit_rob_entry = TAG_ZERO;
      end
      br_flush = flush_s;
      if (flush_s) begin
        flush_pc = tgt_r[head_r];
      end else begin
        flush_pc = 32'h0000_0000;
      end
    end
  end

  // Pointer and occupancy update: reset, flush, or normal alloc/commit accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= TAG_ZERO;
      tail_r  <= TAG_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush_s) begin
      // The mispredicted head retires; everything younger is squashed.
      head_r  <= head_r + TAG_ONE;
      tail_r  <= head_r + TAG_ONE;
      count_r <= CNT_ZERO;
    end else begin
      if (alloc_fire_s) begin
        tail_r <= tail_r + TAG_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (commit_s) begin
        head_r <= head_r + TAG_ONE;
      end else begin
        head_r <= head_r;
      end
      case ({alloc_fire_s, commit_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry flags: allocation sets valid, CDB capture sets ready, commit clears both.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      valid_r <= {ROB_LENGTH{1'b0}};
      ready_r <= {ROB_LENGTH{1'b0}};
      mis_r   <= {ROB_LENGTH{1'b0}};
    end else begin
      if (alloc_fire_s) begin
        valid_r[tail_r] <= 1'b1;
        ready_r[tail_r] <= 1'b0;
        mis_r[tail_r]   <= 1'b0;
      end
      if (cdb_hit_s) begin
        ready_r[cdb_rob] <= 1'b1;
        mis_r[cdb_rob]   <= cdb_mispredict;
      end
      // Commit last so a late CDB to the retiring head cannot keep it alive.
      if (commit_s) begin
        valid_r[head_r] <= 1'b0;
        ready_r[head_r] <= 1'b0;
      end
    end
  end

  // Entry payloads: destination on allocation, result and target on CDB capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_LENGTH; i++) begin
        rd_r[i]   <= {ADDR_WIDTH{1'b0}};
        data_r[i] <= {DATA_WIDTH{1'b0}};
        tgt_r[i]  <= 32'h0000_0000;
      end
    end else begin
      if (alloc_fire_s) begin
        rd_r[tail_r] <= alloc_rd;
      end
      if (cdb_hit_s) begin
        data_r[cdb_rob] <= cdb_data;
        tgt_r[cdb_rob]  <= cdb_target;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rob_commit_ctrl
//
// Directed bench for rob_commit_ctrl. Inputs change on the falling edge and
// the combinational outputs are sampled 1 time unit later, well before the
// rising edge that consumes them.
// ---------------------------------------------------------------------------
module tb_rob_commit_ctrl;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_rob_entry;
  logic        rob_we;
  logic [4:0]  rob_rd_addr;
  logic [2:0]  decode_rob_entry;
  logic        cdb_valid;
  logic [2:0]  cdb_rob;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic        regf_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [2:0]  commit_rob_entry;
  logic        br_flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_pass   = 0;

  rob_commit_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_valid      (alloc_valid),
    .alloc_rd         (alloc_rd),
    .alloc_ready      (alloc_ready),
    .alloc_rob_entry  (alloc_rob_entry),
    .rob_we           (rob_we),
    .rob_rd_addr      (rob_rd_addr),
    .decode_rob_entry (decode_rob_entry),
    .cdb_valid        (cdb_valid),
    .cdb_rob          (cdb_rob),
    .cdb_data         (cdb_data),
    .cdb_mispredict   (cdb_mispredict),
    .cdb_target       (cdb_target),
    .regf_we          (regf_we),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .commit_rob_entry (commit_rob_entry),
    .br_flush         (br_flush),
    .flush_pc         (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs on the falling edge, then let them settle.
  task automatic cyc(input logic av, input logic [4:0] ard,
                     input logic cv, input logic [2:0] ctag, input logic [31:0] cdata,
                     input logic cmis, input logic [31:0] ctgt);
    @(negedge clk);
    alloc_valid    = av;
    alloc_rd       = ard;
    cdb_valid      = cv;
    cdb_rob        = ctag;
    cdb_data       = cdata;
    cdb_mispredict = cmis;
    cdb_target     = ctgt;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic alloc(input logic [4:0] ard);
    cyc(1'b1, ard, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cdb(input logic [2:0] ctag, input logic [31:0] cdata);
    cyc(1'b0, 5'd0, 1'b1, ctag, cdata, 1'b0, 32'h0);
  endtask

  // Reset with a live alloc offer to show outputs are held low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_valid = 1'b1;
    alloc_rd = 5'd3;
    cdb_valid = 1'b0;
    #1;
    check("rst_alloc_ready", 64'(alloc_ready), 64'd0);
    check("rst_rob_we", 64'(rob_we), 64'd0);
    check("rst_alloc_tag", 64'(alloc_rob_entry), 64'd0);
    check("rst_regf_we", 64'(regf_we), 64'd0);
    check("rst_br_flush", 64'(br_flush), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    alloc_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_rd = 5'd0;
    cdb_valid = 1'b0; cdb_rob = 3'd0; cdb_data = 32'h0;
    cdb_mispredict = 1'b0; cdb_target = 32'h0;

    // Fill: tags 0..7, then full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(5'(i + 1));
      check("fill_ready", 64'(alloc_ready), 64'd1);
      check("fill_tag", 64'(alloc_rob_entry), 64'(i));
      check("fill_we", 64'(rob_we), 64'd1);
      check("fill_rd", 64'(rob_rd_addr), 64'(i + 1));
      check("fill_dec_tag", 64'(decode_rob_entry), 64'(i));
    end
    alloc(5'd9);
    check("full_ready", 64'(alloc_ready), 64'd0);
    check("full_we", 64'(rob_we), 64'd0);
    check("full_regf_we", 64'(regf_we), 64'd0);

    // Single result: alloc, CDB, commit the cycle after capture
    do_reset();
    alloc(5'd5);
    cdb(3'd0, 32'hDEAD_BEEF);
    check("nobypass_we", 64'(regf_we), 64'd0);
    idle();
    check("c1_we", 64'(regf_we), 64'd1);
    check("c1_rd", 64'(rd_addr), 64'd5);
    check("c1_data", 64'(rd_data), 64'hDEAD_BEEF);
    check("c1_tag", 64'(commit_rob_entry), 64'd0);
    idle();
    check("c1_empty_we", 64'(regf_we), 64'd0);

    // Out-of-order completion, in-order commit
    do_reset();
    alloc(5'd3);
    alloc(5'd4);
    cdb(3'd1, 32'h11);
    cdb(3'd0, 32'h22);
    check("ooo_hold_we", 64'(regf_we), 64'd0);
    idle();
    check("ooo0_we", 64'(regf_we), 64'd1);
    check("ooo0_tag", 64'(commit_rob_entry), 64'd0);
    check("ooo0_rd", 64'(rd_addr), 64'd3);
    check("ooo0_data", 64'(rd_data), 64'h22);
    idle();
    check("ooo1_we", 64'(regf_we), 64'd1);
    check("ooo1_tag", 64'(commit_rob_entry), 64'd1);
    check("ooo1_rd", 64'(rd_addr), 64'd4);
    check("ooo1_data", 64'(rd_data), 64'h11);
    idle();
    check("ooo_done_we", 64'(regf_we), 64'd0);

    // Mispredict at head flushes younger entries
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    cyc(1'b0, 5'd0, 1'b1, 3'd0, 32'h7, 1'b1, 32'h0000_1040);
    check("mp_pre_flush", 64'(br_flush), 64'd0);
    cyc(1'b1, 5'd6, 1'b1, 3'd1, 32'h99, 1'b0, 32'h0);
    check("mp_flush", 64'(br_flush), 64'd1);
    check("mp_pc", 64'(flush_pc), 64'h1040);
    check("mp_regf_we", 64'(regf_we), 64'd1);
    check("mp_rd", 64'(rd_addr), 64'd1);
    check("mp_alloc_ready", 64'(alloc_ready), 64'd0);
    check("mp_rob_we", 64'(rob_we), 64'd0);
    alloc(5'd9);
    check("mp_after_flush", 64'(br_flush), 64'd0);
    check("mp_after_ready", 64'(alloc_ready), 64'd1);
    check("mp_after_tag", 64'(alloc_rob_entry), 64'd1);
    check("mp_after_we", 64'(regf_we), 64'd0);
    cdb(3'd1, 32'h5);
    check("mp_new_wait", 64'(regf_we), 64'd0);
    idle();
    check("mp_new_we", 64'(regf_we), 64'd1);
    check("mp_new_tag", 64'(commit_rob_entry), 64'd1);
    check("mp_new_rd", 64'(rd_addr), 64'd9);
    check("mp_new_data", 64'(rd_data), 64'h5);

    // Full ROB, commit of tag 0, stale CDB, wrap-around allocation
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1));
    cdb(3'd0, 32'h100);
    cyc(1'b1, 5'd20, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0);
    check("wrap_full_ready", 64'(alloc_ready), 64'd0);
    check("wrap_full_we", 64'(rob_we), 64'd0);
    check("wrap_c0_we", 64'(regf_we), 64'd1);
    check("wrap_c0_data", 64'(rd_data), 64'h100);
    cdb(3'd0, 32'hBAD);
    check("wrap_stale_we", 64'(regf_we), 64'd0);
    alloc(5'd20);
    check("wrap_ready", 64'(alloc_ready), 64'd1);
    check("wrap_tag", 64'(alloc_rob_entry), 64'd0);
    for (int k = 1; k < 8; k++) begin
      cdb(3'(k), 32'(k));
      check("wrap_seq_we", 64'(regf_we), (k > 1) ? 64'd1 : 64'd0);
      if (k > 1) check("wrap_seq_tag", 64'(commit_rob_entry), 64'(k - 1));
    end
    idle();
    check("wrap_c7_tag", 64'(commit_rob_entry), 64'd7);
    check("wrap_c7_rd", 64'(rd_addr), 64'd8);
    idle();
    check("wrap_head0_notready", 64'(regf_we), 64'd0);
    check("wrap_one_left_ready", 64'(alloc_ready), 64'd1);
    check("wrap_next_tag", 64'(alloc_rob_entry), 64'd1);

    // Reset mid-operation with a ready head
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 10));
    cdb(3'd0, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    cdb_valid = 1'b0;
    #1;
    check("midrst_regf_we", 64'(regf_we), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_tag", 64'(alloc_rob_entry), 64'd0);
    check("midrst_ready", 64'(alloc_ready), 64'd1);
    check("midrst_no_commit", 64'(regf_we), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
